// File: rtl/rom_fetch_ctrl_if.sv
// Bundle of the start/status, ROM read and output-stream signals of rom_fetch_ctrl.
// The master modport is the controller's view; the slave modport is the environment's.
interface rom_fetch_ctrl_if #(
  parameter int unsigned WR_ADDR_WD = 8,
  parameter int unsigned WR_DATA_WD = 8
);
  logic                  start;
  logic [WR_ADDR_WD-1:0] start_addr;
  logic [WR_ADDR_WD:0]   start_len;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  rd_vld;
  logic [WR_ADDR_WD-1:0] rd_addr;
  logic [WR_DATA_WD-1:0] rd_data;
  logic                  rd_data_out_vld;
  logic                  out_vld;
  logic [WR_DATA_WD-1:0] out_data;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    input  start, start_addr, start_len, rd_data, rd_data_out_vld, out_ready,
    output busy, done, err, rd_vld, rd_addr, out_vld, out_data, out_last
  );

  modport slave (
    output start, start_addr, start_len, rd_data, rd_data_out_vld, out_ready,
    input  busy, done, err, rd_vld, rd_addr, out_vld, out_data, out_last
  );
endinterface

// File: rtl/rom_fetch_ctrl.sv
// Burst read controller: walks a ROM address range and buffers the one-cycle-latency
// responses in a credit-managed FIFO. Optional macro ROM_FETCH_WRAP_EN enables wrap-around.
module rom_fetch_ctrl #(
  parameter int unsigned WR_ADDR_WD = 8,
  parameter int unsigned WR_DATA_WD = 8,
  parameter int unsigned DATA_DEPTH = 48,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic             clk,
  input logic             reset,
  rom_fetch_ctrl_if.master bus
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SumW = CntW + 1;

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StFin} state_e;

  state_e                state_q, state_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [WR_ADDR_WD-1:0] rd_addr_q, rd_addr_d;
  logic [WR_ADDR_WD:0]   issue_left_q, issue_left_d;
  logic [WR_ADDR_WD:0]   pop_left_q, pop_left_d;
  logic                  inflight_q, inflight_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [PtrW-1:0]       wptr_q, wptr_d;
  logic [PtrW-1:0]       rptr_q, rptr_d;
  logic [WR_DATA_WD-1:0] mem_q [FIFO_DEPTH];

  logic                  push, pop, credit_ok, range_bad;
  logic [SumW-1:0]       credit_sum;
  logic [WR_ADDR_WD-1:0] first_addr, next_addr;

`ifdef ROM_FETCH_WRAP_EN
  assign range_bad  = 1'b0;
  assign first_addr = WR_ADDR_WD'(32'(bus.start_addr) % DATA_DEPTH);
  assign next_addr  = (rd_addr_q == WR_ADDR_WD'(DATA_DEPTH - 1)) ? '0 : rd_addr_q + 1'b1;
`else
  assign range_bad  = (32'(bus.start_addr) >= DATA_DEPTH) ||
                      ((32'(bus.start_addr) + 32'(bus.start_len)) > DATA_DEPTH);
  assign first_addr = bus.start_addr;
  assign next_addr  = rd_addr_q + 1'b1;
`endif

  assign push = bus.rd_data_out_vld && inflight_q;
  assign pop  = (cnt_q != '0) && bus.out_ready;

  // Reserve a slot for the request in flight and the response arriving now.
  assign credit_sum = SumW'(cnt_q) + SumW'(rd_vld_q) + SumW'(inflight_q);
  assign credit_ok  = credit_sum < SumW'(FIFO_DEPTH);

  always_comb begin
    state_d      = state_q;
    rd_vld_d     = 1'b0;
    rd_addr_d    = rd_addr_q;
    issue_left_d = issue_left_q;
    pop_left_d   = pop ? pop_left_q - 1'b1 : pop_left_q;
    err_d        = 1'b0;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          if (bus.start_len == '0) begin
            state_d = StFin;
          end else if (range_bad) begin
            state_d = StFin;
            err_d   = 1'b1;
          end else begin
            state_d      = StFetch;
            rd_vld_d     = 1'b1;
            rd_addr_d    = first_addr;
            issue_left_d = bus.start_len - 1'b1;
            pop_left_d   = bus.start_len;
          end
        end
      end
      StFetch: begin
        if (issue_left_q == '0) begin
          state_d = StDrain;
        end else if (credit_ok) begin
          rd_vld_d     = 1'b1;
          rd_addr_d    = next_addr;
          issue_left_d = issue_left_q - 1'b1;
          if (issue_left_q == 1) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && pop_left_q == 1) state_d = StFin;
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    done_d     = (state_d == StFin);
    busy_d     = (state_d != StIdle);
    inflight_d = rd_vld_q;
  end

  always_comb begin
    cnt_d  = cnt_q;
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      rd_vld_q     <= 1'b0;
      rd_addr_q    <= '0;
      issue_left_q <= '0;
      pop_left_q   <= '0;
      inflight_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      cnt_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
    end else begin
      state_q      <= state_d;
      rd_vld_q     <= rd_vld_d;
      rd_addr_q    <= rd_addr_d;
      issue_left_q <= issue_left_d;
      pop_left_q   <= pop_left_d;
      inflight_q   <= inflight_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      cnt_q        <= cnt_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
    end
  end

  // Storage needs no reset; the read port is gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q] <= bus.rd_data;
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.rd_vld   = rd_vld_q;
  assign bus.rd_addr  = rd_addr_q;
  assign bus.out_vld  = (cnt_q != '0);
  assign bus.out_data = (cnt_q != '0) ? mem_q[rptr_q] : '0;
  assign bus.out_last = (cnt_q != '0) && (pop_left_q == 1);

endmodule

// File: tb/tb_rom_fetch_ctrl.sv
// Self-checking bench for rom_fetch_ctrl: ROM model plus a queue-based burst reference.
module tb_rom_fetch_ctrl;

  localparam int AW    = 8;
  localparam int DW    = 8;
  localparam int DEPTH = 48;
  localparam int FDEP  = 4;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] rom_mem [256];

  rom_fetch_ctrl_if #(.WR_ADDR_WD(AW), .WR_DATA_WD(DW)) bus_if ();

  rom_fetch_ctrl #(
    .WR_ADDR_WD(AW),
    .WR_DATA_WD(DW),
    .DATA_DEPTH(DEPTH),
    .FIFO_DEPTH(FDEP)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial forever #5 clk = ~clk;

  // ROM: one-cycle read latency, never reset.
  always_ff @(posedge clk) begin
    bus_if.rd_data_out_vld <= bus_if.rd_vld;
    bus_if.rd_data         <= rom_mem[bus_if.rd_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", 32'(bus_if.busy), 32'(0));
    check("rst_done", 32'(bus_if.done), 32'(0));
    check("rst_err", 32'(bus_if.err), 32'(0));
    check("rst_rd_vld", 32'(bus_if.rd_vld), 32'(0));
    check("rst_rd_addr", 32'(bus_if.rd_addr), 32'(0));
    check("rst_out_vld", 32'(bus_if.out_vld), 32'(0));
    check("rst_out_data", 32'(bus_if.out_data), 32'(0));
    check("rst_out_last", 32'(bus_if.out_last), 32'(0));
  endtask

  // mode 0: ready always high, 1: ready one cycle in three, 2: random ready.
  task automatic run_burst(input logic [AW-1:0] addr, input logic [AW:0] len, input int mode,
                           input bit spur);
    logic [AW-1:0] exp_addr_q [$];
    logic [DW-1:0] exp_data_q [$];
    logic [AW-1:0] a;
    bit            reject, empty, rdy, fin;
    int            cyc, issued, popped, last_pop;
`ifdef ROM_FETCH_WRAP_EN
    reject = 1'b0;
    a      = AW'(int'(addr) % DEPTH);
`else
    reject = (int'(addr) >= DEPTH) || (int'(addr) + int'(len) > DEPTH);
    a      = addr;
`endif
    empty = reject || (len == 0);
    if (!empty) begin
      for (int i = 0; i < int'(len); i++) begin
        exp_addr_q.push_back(a);
        exp_data_q.push_back(rom_mem[a]);
`ifdef ROM_FETCH_WRAP_EN
        a = (int'(a) == DEPTH - 1) ? '0 : a + 1'b1;
`else
        a = a + 1'b1;
`endif
      end
    end
    bus_if.start      = 1'b1;
    bus_if.start_addr = addr;
    bus_if.start_len  = len;
    bus_if.out_ready  = (mode == 0);
    cyc      = 0;
    issued   = 0;
    popped   = 0;
    last_pop = 0;
    fin      = 1'b0;
    while (!fin) begin
      @(negedge clk);
      cyc++;
      bus_if.start = 1'b0;
      if (spur && cyc == 4) begin
        bus_if.start      = 1'b1;
        bus_if.start_addr = AW'($urandom_range(0, DEPTH - 1));
        bus_if.start_len  = (AW + 1)'($urandom_range(1, 20));
      end
      if (cyc == 1) begin
        check("busy_n1", 32'(bus_if.busy), 32'(1));
        if (empty) check("done_n1", 32'(bus_if.done), 32'(1));
        else       check("rd_vld_n1", 32'(bus_if.rd_vld), 32'(1));
      end
      if (empty) begin
        check("no_rd", 32'(bus_if.rd_vld), 32'(0));
        check("no_out", 32'(bus_if.out_vld), 32'(0));
      end else if (bus_if.rd_vld) begin
        check("credit", 32'((issued - popped) <= FDEP - 1), 32'(1));
        check("rd_in_range", 32'(issued < int'(len)), 32'(1));
        if (exp_addr_q.size() > 0) check("rd_addr", 32'(bus_if.rd_addr), 32'(exp_addr_q.pop_front()));
        issued++;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      bus_if.out_ready = rdy;
      if (bus_if.out_vld && rdy) begin
        if (mode == 0 && popped == 0) check("first_out_cyc", 32'(cyc), 32'(3));
        check("out_in_range", 32'(popped < int'(len)), 32'(1));
        if (exp_data_q.size() > 0) check("out_data", 32'(bus_if.out_data), 32'(exp_data_q.pop_front()));
        check("out_last", 32'(bus_if.out_last), 32'(popped + 1 == int'(len)));
        popped++;
        last_pop = cyc;
      end
      if (bus_if.done) begin
        check("err", 32'(bus_if.err), 32'(reject));
        if (empty) begin
          check("done_cyc", 32'(cyc), 32'(1));
        end else begin
          check("done_cyc", 32'(cyc), 32'(last_pop + 1));
          check("popped", 32'(popped), 32'(len));
          check("issued", 32'(issued), 32'(len));
        end
        fin = 1'b1;
      end else if (cyc > 400) begin
        check("timeout_done", 32'(bus_if.done), 32'(1));
        fin = 1'b1;
      end
    end
    @(negedge clk);
    check("done_pulse", 32'(bus_if.done), 32'(0));
    check("busy_after", 32'(bus_if.busy), 32'(0));
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = DW'($urandom);
    rom_mem[0] = 8'h09;
    rom_mem[1] = 8'h3F;
    rom_mem[2] = 8'hCC;
    rom_mem[3] = 8'hCC;

    reset             = 1'b1;
    bus_if.start      = 1'b0;
    bus_if.start_addr = '0;
    bus_if.start_len  = '0;
    bus_if.out_ready  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;

    run_burst(8'd0, 9'd4, 0, 1'b0);
    run_burst(8'd5, 9'd10, 1, 1'b0);
    run_burst(8'd7, 9'd0, 0, 1'b0);
    run_burst(8'd45, 9'd4, 0, 1'b0);
    run_burst(8'd3, 9'd8, 0, 1'b1);
    run_burst(8'd47, 9'd1, 2, 1'b0);

    // Reset while a read is in flight; the late ROM response must be dropped.
    bus_if.start      = 1'b1;
    bus_if.start_addr = 8'd10;
    bus_if.start_len  = 9'd20;
    bus_if.out_ready  = 1'b1;
    @(negedge clk);
    bus_if.start = 1'b0;
    @(negedge clk);
    check("pre_rst_rd", 32'(bus_if.rd_vld), 32'(1));
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_out", 32'(bus_if.out_vld), 32'(0));
      check("post_rst_rd", 32'(bus_if.rd_vld), 32'(0));
    end
    run_burst(8'd0, 9'd4, 0, 1'b0);

    for (int n = 0; n < 20; n++) begin
      run_burst(AW'($urandom_range(0, 50)), (AW + 1)'($urandom_range(0, 14)),
                (n % 4 == 0) ? 0 : 2, 1'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
